// File: rtl/serial_add_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// serial_add_pkg : shared state encodings and defaults for serial_adder
// Rev 1.0
// ---------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fa.sv
`default_nettype none
// ---------------------------------------------------------------
// fa : single-bit full adder
// Rev 1.0
// ---------------------------------------------------------------
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic cy
);

  assign s  = a ^ b ^ ci;
  assign cy = (a & b) | (ci & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------
// serial_adder : bit-serial adder sequencing one fa per clock, LSB first
// Rev 1.0
// ---------------------------------------------------------------
module serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_cy;
  logic             last_bit;

  fa u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .cy (fa_cy)
  );

  assign last_bit = (cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          carry <= fa_cy;
          s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          if (last_bit) begin
            sum  <= {fa_s, s_sr[WIDTH-1:1]};
            cout <= fa_cy;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_serial_adder : directed and back-to-back bench for serial_adder
// Rev 1.0
// ---------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic        start8,  cin8,  busy8,  done8,  cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start2,  cin2,  busy2,  done2,  cout2;
  logic [1:0]  a2, b2, sum2;
  logic        start32, cin32, busy32, done32, cout32;
  logic [31:0] a32, b32, sum32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );
  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic st);
    case (w)
      2:  begin a2  = av[1:0]; b2  = bv[1:0]; cin2  = ci; start2  = st; end
      32: begin a32 = av;      b32 = bv;      cin32 = ci; start32 = st; end
      default: begin a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; start8 = st; end
    endcase
  endtask

  task automatic sample(input int w, output logic d, output logic bz,
                        output logic [31:0] s, output logic co);
    case (w)
      2:  begin d = done2;  bz = busy2;  s = {30'd0, sum2}; co = cout2;  end
      32: begin d = done32; bz = busy32; s = sum32;         co = cout32; end
      default: begin d = done8; bz = busy8; s = {24'd0, sum8}; co = cout8; end
    endcase
  endtask

  // One operation: inputs are scrambled after the accept edge; an optional
  // competing start is pulsed at step 'disturb'.
  task automatic runw(input int w, input logic [31:0] av, input logic [31:0] bv,
                      input logic ci, input logic [31:0] es, input logic ec,
                      input int disturb, input string tag);
    int first, npulse;
    logic d, bz, co;
    logic [31:0] s;
    first  = -1;
    npulse = 0;
    drive(w, av, bv, ci, 1'b1);
    @(negedge clk);
    for (int k = 1; k <= w + 12; k++) begin
      if (k == disturb) drive(w, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
      else              drive(w, ~av, ~bv, ~ci, 1'b0);
      @(negedge clk);
      sample(w, d, bz, s, co);
      if (k == 1) chk({tag, "_busy_rise"}, 64'(bz), 64'd1);
      if (d) begin
        npulse++;
        if (first < 0) first = k;
      end
    end
    chk({tag, "_latency"}, 64'(first), 64'(w));
    chk({tag, "_pulses"},  64'(npulse), 64'd1);
    chk({tag, "_sum"},     64'(s), 64'(es));
    chk({tag, "_cout"},    64'(co), 64'(ec));
    chk({tag, "_idle"},    64'(bz), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic d, bz, co;
    logic [31:0] s;
    int npulse;
    logic [8:0] q[$];
    logic [8:0] exp9;
    logic [7:0] ra, rb;
    logic       rc;

    rst = 1'b1;
    drive(8, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    drive(32, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    drive(8, 32'hAA, 32'h55, 1'b1, 1'b1);   // start under reset must be ignored
    @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_sum8",  64'(sum8),  64'd0);
    chk("rst_cout8", 64'(cout8), 64'd0);
    chk("rst_sum32", 64'(sum32), 64'd0);
    rst = 1'b1;
    drive(8, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    runw(8, 32'h5A, 32'h3C, 1'b0, 32'h96, 1'b0, 0, "add_5a_3c");
    runw(8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 0, "add_ff_01");
    runw(8, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 3, "ignore_start");
    runw(8, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, 0, "add_ff_ff_c");

    // reset abort in the middle of an operation
    drive(8, 32'h55, 32'h22, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_sum",  64'(sum8),  64'd0);
    chk("abort_cout", 64'(cout8), 64'd0);
    npulse = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) npulse++;
    end
    chk("abort_no_done", 64'(npulse), 64'd0);
    runw(8, 32'h01, 32'h01, 1'b0, 32'h02, 1'b0, 0, "after_abort");

    // width sweep
    runw(2,  32'h3, 32'h3, 1'b1, 32'h3, 1'b1, 0, "w2_ones");
    runw(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 0, "w32_ones");

    // back-to-back with start held high: accepts every 10 edges
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      drive(8, {24'd0, ra}, {24'd0, rb}, rc, 1'b1);
      if (i % 10 == 0) q.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      @(negedge clk);
      chk("b2b_done", 64'(done8), 64'(i % 10 == 8));
      if (done8) begin
        if (q.size() == 0) begin
          chk("b2b_queue_empty", 64'(q.size()), 64'd1);
        end else begin
          exp9 = q.pop_front();
          chk("b2b_result", 64'({cout8, sum8}), 64'(exp9));
        end
      end
    end
    drive(8, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("b2b_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
